serial_sub: RTL and testbench

Parametrised digit-serial subtractor computing `diff = a - b - bin` over WIDTH bits, DIGIT bits per clock, with a registered borrow chained between digits. It is the multi-bit, clocked successor to the team's 1-bit full subtractor and is intended for area-constrained datapaths that can trade latency for gate count. A start/busy/done handshake frames each operation. Results, borrow-out and signed overflow are held stable until the next accepted start.

---
 rtl/serial_sub_pkg.sv | 15 +
 rtl/serial_sub_digit_sub.sv | 34 +++
 rtl/serial_sub.sv | 143 ++++++++++++++
 tb/tb_serial_sub.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// counter sizing helper.
package serial_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A single-digit operation still needs a one-bit counter to compare against.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_sub_digit_sub.sv
// Combinational DIGIT-bit subtractor with borrow in/out; also exposes the
// borrow entering its top bit so the caller can derive signed overflow.
module digit_sub
    import serial_sub_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             bo_msb_in
);

    logic [DIGIT:0] full;

    // One extra bit of headroom: the MSB of the widened difference is the borrow.
    assign full = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi};
    assign d    = full[DIGIT-1:0];
    assign bo   = full[DIGIT];

    generate
        if (DIGIT == 1) begin : g_one
            assign bo_msb_in = bi;
        end else begin : g_multi
            logic [DIGIT-1:0] lo;
            assign lo = {1'b0, x[DIGIT-2:0]} - {1'b0, y[DIGIT-2:0]}
                        - {{(DIGIT-1){1'b0}}, bi};
            assign bo_msb_in = lo[DIGIT-1];
        end
    endgenerate

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH bits, DIGIT bits per
// clock, framed by a start/busy/done handshake with results held until the next op.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    generate
        if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("serial_sub: WIDTH must be >= 2 and an exact multiple of DIGIT");
        end
    endgenerate

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             done_q, done_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] dg_d;
    logic             dg_bo;
    logic             dg_bmi;
    logic [WIDTH-1:0] res_shift;
    logic             last_digit;

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_digit (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .bi       (brw_q),
        .d        (dg_d),
        .bo       (dg_bo),
        .bo_msb_in(dg_bmi)
    );

    // New digits enter at the MSB so after N shifts digit 0 sits at the LSB.
    generate
        if (DIGIT == WIDTH) begin : g_full_width
            assign res_shift = dg_d;
        end else begin : g_shift
            assign res_shift = {dg_d, res_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign last_digit = (state_q == RUN) && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                res_d = res_shift;
                brw_d = dg_bo;
                cnt_d = cnt_q + 1'b1;
                if (last_digit) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    diff_d  = res_shift;
                    bout_d  = dg_bo;
                    // The last digit's top bit is bit WIDTH-1 of the whole word.
                    ovf_d   = dg_bo ^ dg_bmi;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Bench for serial_sub: directed WIDTH=8 vectors and corner sequences, then a
// randomised sweep over several WIDTH/DIGIT configurations against a model.
module tb_serial_sub;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   sweep_go = 1'b0;
    bit   sweep_fin [9];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- directed instances (WIDTH=8) ----------------
    logic       s1_start, s1_bin, s1_busy, s1_done, s1_bout, s1_ovf;
    logic [7:0] s1_a, s1_b, s1_diff;
    logic       s4_start, s4_bin, s4_busy, s4_done, s4_bout, s4_ovf;
    logic [7:0] s4_a, s4_b, s4_diff;

    serial_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start), .a(s1_a), .b(s1_b), .bin(s1_bin),
        .busy(s1_busy), .done(s1_done), .diff(s1_diff), .bout(s1_bout), .ovf(s1_ovf)
    );

    serial_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start), .a(s4_a), .b(s4_b), .bin(s4_bin),
        .busy(s4_busy), .done(s4_done), .diff(s4_diff), .bout(s4_bout), .ovf(s4_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
    } vec_t;

    vec_t vecs [8];

    // Called at a negedge; returns at the negedge where done is seen (or on timeout).
    // edges = rising edges after the start edge before done became visible.
    task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int edges);
        s1_a = a; s1_b = b; s1_bin = bin; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        edges = 0;
        check("d1_busy_after_start", 32'(s1_busy), 32'd1);
        while (!s1_done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bin,
                       output int edges);
        s4_a = a; s4_b = b; s4_bin = bin; s4_start = 1'b1;
        @(negedge clk);
        s4_start = 1'b0;
        edges = 0;
        while (!s4_done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // ---------------- randomised sweep instances ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_sweep
            localparam int W = (gi < 3) ? 4 : ((gi < 6) ? 8 : 16);
            localparam int D = ((gi % 3) == 0) ? 1 : (((gi % 3) == 1) ? 2 : W);
            localparam int N = W / D;

            logic         r_start, r_bin, r_busy, r_done, r_bout, r_ovf;
            logic [W-1:0] r_a, r_b, r_diff;

            serial_sub #(.WIDTH(W), .DIGIT(D)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(r_start), .a(r_a), .b(r_b), .bin(r_bin),
                .busy(r_busy), .done(r_done), .diff(r_diff), .bout(r_bout), .ovf(r_ovf)
            );

            initial begin : g_run
                logic [W-1:0] ea, eb;
                logic         ec;
                int           ai, bi, ci, sa, sb, r, full, edges;
                int           exp_diff, exp_bout, exp_ovf;
                string        tag;
                r_start = 1'b0; r_a = '0; r_b = '0; r_bin = 1'b0;
                sweep_fin[gi] = 1'b0;
                wait (sweep_go);
                @(negedge clk);
                for (int k = 0; k < 30; k++) begin
                    ea = W'($urandom);
                    eb = W'($urandom);
                    ec = 1'($urandom_range(0, 1));
                    if (k == 0) begin ea = '0; eb = '1; ec = 1'b1; end
                    r_a = ea; r_b = eb; r_bin = ec; r_start = 1'b1;
                    // Reference: plain integer arithmetic on unsigned and signed views.
                    ai = int'(ea); bi = int'(eb); ci = int'(ec);
                    full     = 1 << W;
                    exp_diff = (ai - bi - ci + 2 * full) % full;
                    exp_bout = (ai < bi + ci) ? 1 : 0;
                    sa = (ai >= full / 2) ? ai - full : ai;
                    sb = (bi >= full / 2) ? bi - full : bi;
                    r  = sa - sb - ci;
                    exp_ovf = ((r < -(full / 2)) || (r > full / 2 - 1)) ? 1 : 0;
                    @(negedge clk);
                    edges = 0;
                    while (!r_done && edges <= N + 3) begin
                        r_start = r_busy ? 1'($urandom_range(0, 1)) : 1'b0;
                        r_a = W'($urandom);
                        r_b = W'($urandom);
                        @(negedge clk);
                        edges++;
                    end
                    tag = $sformatf("w%0d_d%0d_op%0d", W, D, k);
                    check({tag, "_latency"}, 32'(edges), 32'(N));
                    check({tag, "_diff"}, 32'(r_diff), 32'(exp_diff));
                    check({tag, "_bout"}, 32'(r_bout), 32'(exp_bout));
                    check({tag, "_ovf"}, 32'(r_ovf), 32'(exp_ovf));
                    if ($urandom_range(0, 1) == 0) begin
                        r_start = 1'b0;
                        @(negedge clk);
                    end
                end
                r_start = 1'b0;
                sweep_fin[gi] = 1'b1;
            end
        end
    endgenerate

    // ---------------- main sequence ----------------
    initial begin : main
        int  edges, dones, fin_cnt;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_bin = 1'b0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_bin = 1'b0;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'h07, 8'h07, 1'b0, 8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        #1;
        check("reset_busy", 32'(s1_busy), 32'd0);
        check("reset_done", 32'(s1_done), 32'd0);
        check("reset_diff", 32'(s1_diff), 32'd0);
        check("reset_bout_ovf", {30'd0, s1_bout, s1_ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, DIGIT=1; each op starts in the previous op's done cycle.
        for (int i = 0; i < 8; i++) begin
            op1(vecs[i].a, vecs[i].b, vecs[i].bin, edges);
            check($sformatf("vec%0d_latency", i), 32'(edges), 32'd8);
            check($sformatf("vec%0d_diff", i), 32'(s1_diff), 32'(vecs[i].diff));
            check($sformatf("vec%0d_bout", i), 32'(s1_bout), 32'(vecs[i].bout));
            check($sformatf("vec%0d_ovf", i), 32'(s1_ovf), 32'(vecs[i].ovf));
        end
        @(negedge clk);
        check("d1_done_single_pulse", 32'(s1_done), 32'd0);
        check("d1_result_held", 32'(s1_diff), 32'h00);

        // DIGIT=4: two-edge latency and a restart in the done cycle.
        op4(8'h3C, 8'h3C, 1'b1, edges);
        check("d4_a_latency", 32'(edges), 32'd2);
        check("d4_a_diff", 32'(s4_diff), 32'hFF);
        check("d4_a_bout", 32'(s4_bout), 32'd1);
        check("d4_a_ovf", 32'(s4_ovf), 32'd0);
        op4(8'h10, 8'h01, 1'b0, edges);
        check("d4_b_latency", 32'(edges), 32'd2);
        check("d4_b_diff", 32'(s4_diff), 32'h0F);
        check("d4_b_bout", 32'(s4_bout), 32'd0);
        @(negedge clk);
        check("d4_done_single_pulse", 32'(s4_done), 32'd0);

        // Start pulsed during the 3rd busy cycle must be ignored.
        s1_a = 8'h09; s1_b = 8'h04; s1_bin = 1'b0; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        edges = 0;
        dones = 0;
        while (!s1_done && edges < 20) begin
            if (edges == 2) begin
                s1_a = 8'hAA; s1_b = 8'h55; s1_start = 1'b1;
            end else begin
                s1_start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        s1_start = 1'b0;
        check("ignore_latency", 32'(edges), 32'd8);
        check("ignore_diff", 32'(s1_diff), 32'h05);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s1_done) dones++;
        end
        check("ignore_no_second_done", 32'(dones), 32'd0);
        check("ignore_not_busy", 32'(s1_busy), 32'd0);

        // Asynchronous reset mid-RUN, with nonzero results held beforehand.
        op1(8'h7F, 8'hFF, 1'b0, edges);
        check("pre_reset_diff", 32'(s1_diff), 32'h80);
        @(negedge clk);
        s1_a = 8'h33; s1_b = 8'h11; s1_bin = 1'b0; s1_start = 1'b1;
        @(negedge clk);
        s1_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_busy", 32'(s1_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(s1_busy), 32'd0);
        check("async_reset_done", 32'(s1_done), 32'd0);
        check("async_reset_diff", 32'(s1_diff), 32'd0);
        check("async_reset_bout", 32'(s1_bout), 32'd0);
        check("async_reset_ovf", 32'(s1_ovf), 32'd0);
        check("async_reset_d4_diff", 32'(s4_diff), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op1(8'h07, 8'h07, 1'b0, edges);
        check("post_reset_latency", 32'(edges), 32'd8);
        check("post_reset_diff", 32'(s1_diff), 32'h00);
        check("post_reset_bout", 32'(s1_bout), 32'd0);
        check("post_reset_ovf", 32'(s1_ovf), 32'd0);

        // Randomised sweep across configurations, bounded by a cycle budget.
        sweep_go = 1'b1;
        fin_cnt = 0;
        for (int c = 0; c < 6000 && fin_cnt < 9; c++) begin
            @(negedge clk);
            fin_cnt = 0;
            for (int j = 0; j < 9; j++) if (sweep_fin[j]) fin_cnt++;
        end
        check("sweep_completed_configs", 32'(fin_cnt), 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
